// File: rtl/alu_exec_stage.sv
// Execute-stage sequencer in front of the ALU: registers one op per handshake,
// holds it on the ALU until the result is ready, then offers a writeback beat.
module alu_exec_stage #(
    parameter int          DST_W      = 3,
    parameter logic [4:0]  IDLE_OPSEL = 5'd0,
    parameter logic [4:0]  POW_OPSEL  = 5'd15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opsel,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [15:0]      in_x,
    input  logic [DST_W-1:0] in_dst,
    input  logic             in_setf,
    input  logic             in_wr_extra,
    output logic [15:0]      alu_srcA,
    output logic [15:0]      alu_srcB,
    output logic [15:0]      alu_extra_X,
    output logic [4:0]       alu_opsel,
    output logic             alu_Cflag,
    output logic             alu_Oflag,
    input  logic [15:0]      alu_res,
    input  logic [15:0]      alu_extra_res,
    input  logic [3:0]       alu_flag_next,
    input  logic             alu_ready,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [DST_W-1:0] wb_dst,
    output logic [15:0]      wb_data,
    output logic             wb_extra_valid,
    output logic [15:0]      wb_extra_data,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;

    state_t            state_q, state_d;
    logic              first_q, first_d;
    logic [4:0]        opsel_q, opsel_d;
    logic [15:0]       a_q, a_d;
    logic [15:0]       b_q, b_d;
    logic [15:0]       x_q, x_d;
    logic [DST_W-1:0]  dst_q, dst_d;
    logic              setf_q, setf_d;
    logic              wr_extra_q, wr_extra_d;
    logic [15:0]       res_q, res_d;
    logic [15:0]       extra_q, extra_d;
    logic [3:0]        flags_q, flags_d;

    logic accept;
    logic capture;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_WB) && wb_ready);
    assign accept   = in_valid && in_ready;
    // POW's ready line may still be high from a previous op on its first cycle.
    assign capture  = (state_q == ST_EXEC) && alu_ready &&
                      !((opsel_q == POW_OPSEL) && first_q);

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        opsel_d    = opsel_q;
        a_d        = a_q;
        b_d        = b_q;
        x_d        = x_q;
        dst_d      = dst_q;
        setf_d     = setf_q;
        wr_extra_d = wr_extra_q;
        res_d      = res_q;
        extra_d    = extra_q;
        flags_d    = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                first_d = 1'b0;
                if (capture) begin
                    res_d   = alu_res;
                    extra_d = alu_extra_res;
                    if (setf_q) flags_d = alu_flag_next;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (wb_ready) state_d = accept ? ST_EXEC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            first_d    = 1'b1;
            opsel_d    = in_opsel;
            a_d        = in_a;
            b_d        = in_b;
            x_d        = in_x;
            dst_d      = in_dst;
            setf_d     = in_setf;
            wr_extra_d = in_wr_extra;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b0;
            opsel_q    <= IDLE_OPSEL;
            a_q        <= '0;
            b_q        <= '0;
            x_q        <= '0;
            dst_q      <= '0;
            setf_q     <= 1'b0;
            wr_extra_q <= 1'b0;
            res_q      <= '0;
            extra_q    <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            opsel_q    <= opsel_d;
            a_q        <= a_d;
            b_q        <= b_d;
            x_q        <= x_d;
            dst_q      <= dst_d;
            setf_q     <= setf_d;
            wr_extra_q <= wr_extra_d;
            res_q      <= res_d;
            extra_q    <= extra_d;
            flags_q    <= flags_d;
        end
    end

    // Outside EXEC the ALU sees a harmless op so it never starts POW spuriously.
    assign alu_opsel      = (state_q == ST_EXEC) ? opsel_q : IDLE_OPSEL;
    assign alu_srcA       = a_q;
    assign alu_srcB       = b_q;
    assign alu_extra_X    = x_q;
    assign alu_Cflag      = flags_q[1];
    assign alu_Oflag      = flags_q[0];

    assign wb_valid       = (state_q == ST_WB);
    assign wb_dst         = dst_q;
    assign wb_data        = res_q;
    assign wb_extra_valid = (state_q == ST_WB) && wr_extra_q;
    assign wb_extra_data  = extra_q;
    assign flags          = flags_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a small behavioural ALU stub.
module tb_alu_exec_stage;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_MUL = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_POW = 5'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opsel;
    logic [15:0] in_a, in_b, in_x;
    logic [2:0]  in_dst;
    logic        in_setf, in_wr_extra;
    logic [15:0] alu_srcA, alu_srcB, alu_extra_X;
    logic [4:0]  alu_opsel;
    logic        alu_Cflag, alu_Oflag;
    logic [15:0] alu_res, alu_extra_res;
    logic [3:0]  alu_flag_next;
    logic        alu_ready;
    logic        wb_valid, wb_ready;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic        wb_extra_valid;
    logic [15:0] wb_extra_data;
    logic [3:0]  flags;

    logic        pow_ready;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.DST_W(3), .IDLE_OPSEL(OP_NOP), .POW_OPSEL(OP_POW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opsel(in_opsel),
        .in_a(in_a), .in_b(in_b), .in_x(in_x), .in_dst(in_dst),
        .in_setf(in_setf), .in_wr_extra(in_wr_extra),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_extra_X(alu_extra_X),
        .alu_opsel(alu_opsel), .alu_Cflag(alu_Cflag), .alu_Oflag(alu_Oflag),
        .alu_res(alu_res), .alu_extra_res(alu_extra_res),
        .alu_flag_next(alu_flag_next), .alu_ready(alu_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst),
        .wb_data(wb_data), .wb_extra_valid(wb_extra_valid),
        .wb_extra_data(wb_extra_data), .flags(flags)
    );

    // Behavioural ALU stub: C = carry (ADD) or borrow (SUB), O = signed overflow.
    function automatic logic [15:0] pow16(input logic [15:0] base, input logic [15:0] e);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < 16; i++)
            if (i < int'(e)) r = r * base;
        return r;
    endfunction

    logic [16:0] sum17;
    logic [31:0] prod32;
    logic [15:0] r16;
    logic        c_s, o_s;

    always_comb begin
        sum17 = '0;
        prod32 = '0;
        r16 = '0;
        c_s = 1'b0;
        o_s = 1'b0;
        alu_extra_res = '0;
        alu_ready = 1'b1;
        case (alu_opsel)
            OP_ADD: begin
                sum17 = {1'b0, alu_srcA} + {1'b0, alu_srcB};
                r16 = sum17[15:0];
                c_s = sum17[16];
                o_s = (alu_srcA[15] == alu_srcB[15]) && (r16[15] != alu_srcA[15]);
            end
            OP_SUB: begin
                r16 = alu_srcA - alu_srcB;
                c_s = alu_srcA < alu_srcB;
                o_s = (alu_srcA[15] != alu_srcB[15]) && (r16[15] != alu_srcA[15]);
            end
            OP_MUL: begin
                prod32 = alu_srcA * alu_srcB;
                r16 = prod32[15:0];
                alu_extra_res = prod32[31:16];
            end
            OP_AND: r16 = alu_srcA & alu_srcB;
            OP_POW: begin
                r16 = pow16(alu_srcA, alu_srcB);
                alu_ready = pow_ready;
            end
            default: r16 = '0;
        endcase
        alu_res = r16;
        alu_flag_next = {(r16 == 16'h0), r16[15], c_s, o_s};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0]  opsel;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dst;
        logic        setf;
        logic        wr_extra;
        logic [15:0] exp_data;
        logic        exp_xv;
        logic [15:0] exp_extra;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs [6];

    // Drive one op at a negedge while the stage is idle; returns after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] dst, input logic setf, input logic wr_extra);
        @(negedge clk);
        in_opsel = op; in_a = a; in_b = b; in_x = 16'h0;
        in_dst = dst; in_setf = setf; in_wr_extra = wr_extra;
        in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until wb_valid; 0 on timeout.
    task automatic wait_wb(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (wb_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("wb_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume_wb();
        wb_ready = 1'b1;
        @(posedge clk);
        #1 wb_ready = 1'b0;
    endtask

    initial begin
        int lat;
        vec_t v;

        rst = 1'b0; in_valid = 1'b0; wb_ready = 1'b0; pow_ready = 1'b1;
        in_opsel = '0; in_a = '0; in_b = '0; in_x = '0;
        in_dst = '0; in_setf = 1'b0; in_wr_extra = 1'b0;

        vecs[0] = '{OP_ADD, 16'h7FFF, 16'h0001, 3'd2, 1'b1, 1'b0, 16'h8000, 1'b0, 16'h0000, 4'b0101};
        vecs[1] = '{OP_AND, 16'hF0F0, 16'h0F0F, 3'd3, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b0101};
        vecs[2] = '{OP_MUL, 16'h0100, 16'h0100, 3'd7, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001, 4'b0101};
        vecs[3] = '{OP_ADD, 16'hFFFF, 16'h0001, 3'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b1010};
        vecs[4] = '{OP_SUB, 16'h0005, 16'h0007, 3'd4, 1'b1, 1'b0, 16'hFFFE, 1'b0, 16'h0000, 4'b0110};
        vecs[5] = '{OP_AND, 16'hFFFF, 16'h8000, 3'd0, 1'b1, 1'b0, 16'h8000, 1'b0, 16'h0000, 4'b0100};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_wb_valid", wb_valid, 1'b0);
        check("reset_flags", flags, 4'h0);
        check("reset_alu_opsel", alu_opsel, OP_NOP);
        check("reset_wb_data", wb_data, 16'h0);
        rst = 1'b1;

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            issue(v.opsel, v.a, v.b, v.dst, v.setf, v.wr_extra);
            wait_wb(lat);
            $display("op %0d: opsel=%0d a=%h b=%h -> lat=%0d dst=%0d data=%h xv=%0b x=%h flags=%b",
                     k, v.opsel, v.a, v.b, lat, wb_dst, wb_data, wb_extra_valid, wb_extra_data, flags);
            check("latency", lat, 2);
            check("wb_dst", wb_dst, v.dst);
            check("wb_data", wb_data, v.exp_data);
            check("wb_extra_valid", wb_extra_valid, v.exp_xv);
            check("wb_extra_data", wb_extra_data, v.exp_extra);
            check("flags", flags, v.exp_flags);
            check("alu_Cflag", alu_Cflag, v.exp_flags[1]);
            check("alu_Oflag", alu_Oflag, v.exp_flags[0]);
            check("alu_opsel_in_wb", alu_opsel, OP_NOP);
            consume_wb();
        end

        // POW: stale ready in the first EXEC cycle must be ignored.
        pow_ready = 1'b1;
        issue(OP_POW, 16'd3, 16'd4, 3'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("pow_opsel_exec", alu_opsel, OP_POW);
        #1 pow_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pow_no_early_wb", wb_valid, 1'b0);
            check("pow_srcA_stable", alu_srcA, 16'd3);
            check("pow_srcB_stable", alu_srcB, 16'd4);
        end
        pow_ready = 1'b1;
        wait_wb(lat);
        $display("pow: lat_after_ready=%0d dst=%0d data=%h flags=%b", lat, wb_dst, wb_data, flags);
        check("pow_lat_after_ready", lat, 1);
        check("pow_data", wb_data, 16'h0051);
        check("pow_flags_kept", flags, 4'b0100);
        consume_wb();

        // Back-pressure with a waiting op, then same-cycle handoff.
        issue(OP_ADD, 16'd1, 16'd2, 3'd5, 1'b0, 1'b0);
        wait_wb(lat);
        in_opsel = OP_ADD; in_a = 16'd3; in_b = 16'd4; in_dst = 3'd6;
        in_setf = 1'b0; in_wr_extra = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", in_ready, 1'b0);
            check("bp_wb_valid", wb_valid, 1'b1);
            check("bp_wb_data", wb_data, 16'd3);
            check("bp_wb_dst", wb_dst, 3'd5);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1 check("bp_in_ready_with_wb_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 begin wb_ready = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        check("b2b_exec_no_wb", wb_valid, 1'b0);
        check("b2b_opsel", alu_opsel, OP_ADD);
        @(negedge clk);
        $display("b2b: wb_valid=%0b dst=%0d data=%h", wb_valid, wb_dst, wb_data);
        check("b2b_wb_valid", wb_valid, 1'b1);
        check("b2b_wb_data", wb_data, 16'd7);
        check("b2b_wb_dst", wb_dst, 3'd6);
        consume_wb();

        // Reset asserted mid-EXEC of a flag-setting op.
        issue(OP_ADD, 16'h7FFF, 16'h0001, 3'd2, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rst_flags", flags, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_alu_opsel", alu_opsel, OP_NOP);
        check("rst_srcA", alu_srcA, 16'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_wb", wb_valid, 1'b0);
            check("post_rst_flags", flags, 4'h0);
        end
        $display("reset mid-exec: flags=%b wb_valid=%0b", flags, wb_valid);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
